// File: rtl/pipeline_step_controller_pkg.sv
// Shared definitions for the pipeline step controller: debug-host command
// opcodes, FSM state encodings and the clogb2 width helper.
package pipeline_step_controller_pkg;

   localparam logic [2:0] CMD_NOP    = 3'b000;
   localparam logic [2:0] CMD_RUN    = 3'b001;
   localparam logic [2:0] CMD_STEP   = 3'b010;
   localparam logic [2:0] CMD_STOP   = 3'b011;
   localparam logic [2:0] CMD_CLEAR  = 3'b100;
   localparam logic [2:0] CMD_SET_BP = 3'b101;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_RUN    = 3'd1,
      ST_STEP   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } state_t;

   // Bits needed to hold the values 0 .. value-1 (never less than 1).
   function automatic int clogb2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/pipeline_step_controller_cycle_counter.sv
// pipeline_cycle_counter: counts enabled pipeline cycles for the debug unit.
// Saturates at all-ones; a synchronous clear has priority over counting.
module pipeline_cycle_counter #(
   parameter int CANT_BITS_CICLOS = 32
) (
   input  logic                        i_clock,
   input  logic                        i_soft_reset,
   input  logic                        i_enable,
   input  logic                        i_clear,
   output logic [CANT_BITS_CICLOS-1:0] o_count
);

   logic [CANT_BITS_CICLOS-1:0] r_count;

   // Count enabled edges, hold at all-ones instead of wrapping.
   always_ff @(posedge i_clock or posedge i_soft_reset) begin
      if (i_soft_reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/pipeline_step_controller.sv
// pipeline_step_controller: drives the shared pipeline enable from debug-host
// commands (RUN / STEP / STOP / CLEAR / SET_BP), drains the pipeline after a
// HALT reaches ID and counts enabled cycles.
// Optional breakpoint support is compiled in with the BREAKPOINT_EN macro.
//
// Command handshake: a command is consumed on a rising edge where both
// i_cmd_valid and o_cmd_ready are high; the host holds i_cmd/i_cmd_data
// stable while valid is high and ready is low. o_cmd_ready depends only on
// the state register.
module pipeline_step_controller
   import pipeline_step_controller_pkg::*;
#(
   parameter int CANT_BITS_ADDR   = 11,
   parameter int CANT_BITS_CICLOS = 32,
   parameter int DRAIN_CYCLES     = 3,
   parameter int CANT_BITS_CMD    = 3
) (
   input  logic                        i_clock,
   input  logic                        i_soft_reset,
   input  logic                        i_cmd_valid,
   input  logic [CANT_BITS_CMD-1:0]    i_cmd,
   input  logic [CANT_BITS_ADDR-1:0]   i_cmd_data,
   output logic                        o_cmd_ready,
   input  logic                        i_halt_detected,
   input  logic [CANT_BITS_ADDR-1:0]   i_pc,
   output logic                        o_enable_pipeline,
   output logic [CANT_BITS_CICLOS-1:0] o_cycle_count,
   output logic                        o_busy,
   output logic                        o_halted,
   output logic                        o_bp_hit,
   output logic                        o_led
);

   localparam int DRAIN_W = clogb2(DRAIN_CYCLES + 1);

   state_t             r_state;
   state_t             w_state_next;
   logic [DRAIN_W-1:0] r_drain_cnt;
   logic [DRAIN_W-1:0] w_drain_next;
   logic               w_cnt_clear;
   logic               w_enable;
   logic               w_take;
   logic               w_take_run;
   logic               w_take_step;
   logic               w_take_stop;
   logic               w_take_clear;
   logic               w_bp_match;

   assign w_take       = i_cmd_valid && o_cmd_ready;
   assign w_take_run   = w_take && (i_cmd == CANT_BITS_CMD'(CMD_RUN));
   assign w_take_step  = w_take && (i_cmd == CANT_BITS_CMD'(CMD_STEP));
   assign w_take_stop  = w_take && (i_cmd == CANT_BITS_CMD'(CMD_STOP));
   assign w_take_clear = w_take && (i_cmd == CANT_BITS_CMD'(CMD_CLEAR));

   // State and drain counter registers.
   always_ff @(posedge i_clock or posedge i_soft_reset) begin
      if (i_soft_reset) begin
         r_state     <= ST_IDLE;
         r_drain_cnt <= '0;
      end else begin
         r_state     <= w_state_next;
         r_drain_cnt <= w_drain_next;
      end
   end

   // Next-state logic; a HALT seen in RUN or STEP wins over everything else.
   always_comb begin
      w_state_next = r_state;
      w_drain_next = r_drain_cnt;
      w_cnt_clear  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_take_run) begin
               w_state_next = ST_RUN;
            end else if (w_take_step) begin
               w_state_next = ST_STEP;
            end else if (w_take_clear) begin
               w_cnt_clear = 1'b1;
            end
         end
         ST_RUN, ST_STEP: begin
            if (i_halt_detected) begin
               if (DRAIN_CYCLES == 0) begin
                  w_state_next = ST_HALTED;
               end else begin
                  w_state_next = ST_DRAIN;
                  w_drain_next = DRAIN_W'(DRAIN_CYCLES);
               end
            end else if (r_state == ST_STEP) begin
               w_state_next = ST_IDLE;
            end else if (w_take_stop || w_bp_match) begin
               w_state_next = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (r_drain_cnt <= DRAIN_W'(1)) begin
               w_state_next = ST_HALTED;
               w_drain_next = '0;
            end else begin
               w_drain_next = r_drain_cnt - DRAIN_W'(1);
            end
         end
         ST_HALTED: begin
            if (w_take_clear) begin
               w_state_next = ST_IDLE;
               w_cnt_clear  = 1'b1;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Moore outputs decoded from the state register only.
   assign w_enable          = (r_state == ST_RUN) || (r_state == ST_STEP) || (r_state == ST_DRAIN);
   assign o_enable_pipeline = w_enable;
   assign o_busy            = w_enable;
   assign o_cmd_ready       = (r_state == ST_IDLE) || (r_state == ST_RUN) || (r_state == ST_HALTED);
   assign o_halted          = (r_state == ST_HALTED);
   assign o_led             = o_halted;

   pipeline_cycle_counter #(
      .CANT_BITS_CICLOS (CANT_BITS_CICLOS)
   ) u_cycle_counter (
      .i_clock      (i_clock),
      .i_soft_reset (i_soft_reset),
      .i_enable     (w_enable),
      .i_clear      (w_cnt_clear),
      .o_count      (o_cycle_count)
   );

`ifdef BREAKPOINT_EN
   logic [CANT_BITS_ADDR-1:0] r_bp_addr;
   logic                      r_bp_valid;
   logic                      r_bp_hit;
   logic                      w_take_setbp;

   assign w_take_setbp = w_take && (i_cmd == CANT_BITS_CMD'(CMD_SET_BP));
   assign w_bp_match   = (r_state == ST_RUN) && r_bp_valid && (i_pc == r_bp_addr) && !i_halt_detected;

   // Breakpoint address load and sticky hit flag; a new hit beats a clear.
   always_ff @(posedge i_clock or posedge i_soft_reset) begin
      if (i_soft_reset) begin
         r_bp_addr  <= '0;
         r_bp_valid <= 1'b0;
         r_bp_hit   <= 1'b0;
      end else begin
         if (w_take_setbp && ((r_state == ST_IDLE) || (r_state == ST_HALTED))) begin
            r_bp_addr  <= i_cmd_data;
            r_bp_valid <= 1'b1;
         end
         if (w_bp_match) begin
            r_bp_hit <= 1'b1;
         end else if (w_take_run || w_take_step || w_take_clear) begin
            r_bp_hit <= 1'b0;
         end
      end
   end

   assign o_bp_hit = r_bp_hit;
`else
   logic w_unused_bp;

   assign w_bp_match  = 1'b0;
   assign o_bp_hit    = 1'b0;
   assign w_unused_bp = ^{i_pc, i_cmd_data};
`endif

endmodule

// File: tb/tb_pipeline_step_controller.sv
// Directed/randomized bench for pipeline_step_controller. Expected values come
// from scenario-level arithmetic (enabled-cycle totals, per-cycle patterns)
// rather than a state-by-state copy of the controller.
module tb_pipeline_step_controller;

   localparam int AW    = 11;
   localparam int CW    = 32;
   localparam int DRAIN = 3;
   localparam int MW    = 3;

   localparam logic [2:0] OP_NOP    = 3'd0;
   localparam logic [2:0] OP_RUN    = 3'd1;
   localparam logic [2:0] OP_STEP   = 3'd2;
   localparam logic [2:0] OP_STOP   = 3'd3;
   localparam logic [2:0] OP_CLEAR  = 3'd4;
   localparam logic [2:0] OP_SET_BP = 3'd5;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          cmd_valid = 1'b0;
   logic [MW-1:0] cmd       = OP_NOP;
   logic [AW-1:0] cmd_data  = '0;
   logic          halt      = 1'b0;
   logic [AW-1:0] pc        = 11'h100;
   logic          cmd_ready;
   logic          en;
   logic [CW-1:0] count;
   logic          busy;
   logic          halted;
   logic          bp_hit;
   logic          led;

   logic          sc_en  = 1'b0;
   logic          sc_clr = 1'b0;
   logic [2:0]    sc_count;

   pipeline_step_controller #(
      .CANT_BITS_ADDR   (AW),
      .CANT_BITS_CICLOS (CW),
      .DRAIN_CYCLES     (DRAIN),
      .CANT_BITS_CMD    (MW)
   ) dut (
      .i_clock           (clk),
      .i_soft_reset      (rst),
      .i_cmd_valid       (cmd_valid),
      .i_cmd             (cmd),
      .i_cmd_data        (cmd_data),
      .o_cmd_ready       (cmd_ready),
      .i_halt_detected   (halt),
      .i_pc              (pc),
      .o_enable_pipeline (en),
      .o_cycle_count     (count),
      .o_busy            (busy),
      .o_halted          (halted),
      .o_bp_hit          (bp_hit),
      .o_led             (led)
   );

   // Narrow counter instance so saturation is reachable in a short run.
   pipeline_cycle_counter #(
      .CANT_BITS_CICLOS (3)
   ) u_sat (
      .i_clock      (clk),
      .i_soft_reset (rst),
      .i_enable     (sc_en),
      .i_clear      (sc_clr),
      .o_count      (sc_count)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_err    = 0;
   int m_count  = 0;   // expected o_cycle_count
   int obs_en   = 0;   // enabled cycles observed on the enable line
   logic [1:0] exp_q[$];

   always @(negedge clk) begin
      if (en === 1'b1) obs_en <= obs_en + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Every task starts and ends 1 ns after a rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_cmd(input logic [2:0] op, input logic [AW-1:0] data);
      bit taken;
      taken     = 1'b0;
      cmd_valid = 1'b1;
      cmd       = op;
      cmd_data  = data;
      for (int t = 0; t < 40 && !taken; t++) begin
         taken = (cmd_ready === 1'b1);
         step();
      end
      cmd_valid = 1'b0;
      cmd       = OP_NOP;
      chk("cmd_accepted", 64'(taken), 64'(1));
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_en"},     64'(en),        64'(0));
      chk({tag, "_busy"},   64'(busy),      64'(0));
      chk({tag, "_ready"},  64'(cmd_ready), 64'(1));
      chk({tag, "_halted"}, 64'(halted),    64'(0));
      chk({tag, "_count"},  64'(count),     64'(m_count));
   endtask

   // RUN, then STOP accepted on the n-th enabled cycle.
   task automatic run_stop(input int n);
      int e0;
      e0 = obs_en;
      send_cmd(OP_RUN, '0);
      chk("run_en",    64'(en),        64'(1));
      chk("run_ready", 64'(cmd_ready), 64'(1));
      chk("run_busy",  64'(busy),      64'(1));
      repeat (n - 1) step();
      send_cmd(OP_STOP, '0);
      m_count += n;
      chk_idle("run_stop");
      chk("run_stop_pulses", 64'(obs_en - e0), 64'(n));
   endtask

   // n STEP commands with valid held; ready and enable alternate each cycle.
   task automatic step_burst(input int n);
      int e0;
      logic [1:0] e;
      e0 = obs_en;
      for (int k = 0; k <= 2 * n; k++) exp_q.push_back({(k % 2 == 0), (k % 2 == 1)});
      cmd = OP_STEP;
      for (int k = 0; k <= 2 * n; k++) begin
         cmd_valid = (k < 2 * n - 1);
         e = exp_q.pop_front();
         chk("step_ready_en", 64'({cmd_ready, en}), 64'(e));
         step();
      end
      cmd_valid = 1'b0;
      cmd       = OP_NOP;
      m_count += n;
      chk_idle("step_burst");
      chk("step_pulses", 64'(obs_en - e0), 64'(n));
   endtask

   // RUN with HALT in the h-th RUN cycle (optionally together with STOP),
   // then drain, park in HALTED, ignore RUN, leave with CLEAR.
   task automatic run_halt(input int h, input bit with_stop);
      int e0;
      e0 = obs_en;
      send_cmd(OP_RUN, '0);
      repeat (h - 1) step();
      halt = 1'b1;
      if (with_stop) send_cmd(OP_STOP, '0);
      else step();
      halt = 1'b0;
      for (int d = 0; d < DRAIN; d++) begin
         chk("drain_en",    64'(en),        64'(1));
         chk("drain_ready", 64'(cmd_ready), 64'(0));
         step();
      end
      m_count += h + DRAIN;
      chk("halt_halted", 64'(halted),      64'(1));
      chk("halt_led",    64'(led),         64'(1));
      chk("halt_en",     64'(en),          64'(0));
      chk("halt_ready",  64'(cmd_ready),   64'(1));
      chk("halt_count",  64'(count),       64'(m_count));
      chk("halt_pulses", 64'(obs_en - e0), 64'(h + DRAIN));
      send_cmd(OP_RUN, '0);
      step();
      chk("halt_run_ign_halted", 64'(halted), 64'(1));
      chk("halt_run_ign_en",     64'(en),     64'(0));
      chk("halt_run_ign_count",  64'(count),  64'(m_count));
      send_cmd(OP_CLEAR, '0);
      m_count = 0;
      chk_idle("halt_clear");
   endtask

   // Breakpoint at 0x014 reached on the b-th RUN cycle.
   task automatic bp_run(input int b);
      int e0;
      int k;
      e0 = obs_en;
      send_cmd(OP_SET_BP, 11'h014);
      pc = 11'h100;
      send_cmd(OP_RUN, '0);
      for (int c = 1; c < b; c++) begin
         pc = 11'h100 + AW'(c);
         step();
      end
      pc = 11'h014;
      step();
      pc = 11'h100;
`ifdef BREAKPOINT_EN
      m_count += b;
      chk("bp_en",     64'(en),     64'(0));
      chk("bp_hit",    64'(bp_hit), 64'(1));
      chk("bp_halted", 64'(halted), 64'(0));
      chk("bp_pulses", 64'(obs_en - e0), 64'(b));
`else
      chk("nobp_en",  64'(en),     64'(1));
      chk("nobp_hit", 64'(bp_hit), 64'(0));
      k = $urandom_range(1, 4);
      repeat (k) step();
      send_cmd(OP_STOP, '0);
      m_count += b + k + 1;
      chk("nobp_pulses", 64'(obs_en - e0), 64'(b + k + 1));
`endif
      chk_idle("bp_stopped");
      send_cmd(OP_STEP, '0);
      chk("bp_step_en",  64'(en),     64'(1));
      chk("bp_step_hit", 64'(bp_hit), 64'(0));
      step();
      m_count += 1;
      chk_idle("bp_step_done");
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #20 rst = 1'b0;
      step();
      chk_idle("reset");
      chk("reset_bp_hit", 64'(bp_hit), 64'(0));
      chk("reset_led",    64'(led),    64'(0));

      // halt while idle is ignored
      halt = 1'b1;
      step();
      halt = 1'b0;
      step();
      chk_idle("idle_halt_ign");

      run_stop(10);
      step_burst(3);
      run_halt(5, 1'b0);
      run_halt($urandom_range(1, 8), 1'b1);

      for (int r = 0; r < 4; r++) begin
         run_stop($urandom_range(1, 15));
         step_burst($urandom_range(1, 4));
         run_halt($urandom_range(1, 8), r[0]);
      end

      // STEP with halt in its enabled cycle: 1 + DRAIN enabled cycles
      send_cmd(OP_STEP, '0);
      halt = 1'b1;
      step();
      halt = 1'b0;
      repeat (DRAIN) step();
      m_count += 1 + DRAIN;
      chk("step_halt_halted", 64'(halted), 64'(1));
      chk("step_halt_count",  64'(count),  64'(m_count));
      send_cmd(OP_CLEAR, '0);
      m_count = 0;
      chk_idle("step_halt_clear");

      bp_run(7);
      bp_run($urandom_range(1, 12));

      // halt and breakpoint in the same cycle: halt wins
      send_cmd(OP_SET_BP, 11'h014);
      send_cmd(OP_RUN, '0);
      step();
      pc   = 11'h014;
      halt = 1'b1;
      step();
      halt = 1'b0;
      pc   = 11'h100;
      repeat (DRAIN) step();
      m_count += 2 + DRAIN;
      chk("bp_halt_halted", 64'(halted), 64'(1));
      chk("bp_halt_hit",    64'(bp_hit), 64'(0));
      chk("bp_halt_count",  64'(count),  64'(m_count));
      send_cmd(OP_CLEAR, '0);
      m_count = 0;
      chk_idle("bp_halt_clear");

      // asynchronous reset in the middle of RUN
      send_cmd(OP_RUN, '0);
      repeat (4) step();
      #2 rst = 1'b1;
      #1;
      m_count = 0;
      chk("arst_en",    64'(en),        64'(0));
      chk("arst_count", 64'(count),     64'(0));
      chk("arst_ready", 64'(cmd_ready), 64'(1));
      @(negedge clk);
      rst = 1'b0;
      step();
      chk_idle("arst_after");

      // saturating counter, 3 bits wide
      sc_en = 1'b1;
      repeat (5) step();
      chk("sat_count5", 64'(sc_count), 64'(5));
      repeat (5) step();
      chk("sat_count_max", 64'(sc_count), 64'(7));
      sc_clr = 1'b1;
      step();
      chk("sat_clear", 64'(sc_count), 64'(0));
      sc_clr = 1'b0;
      sc_en  = 1'b0;
      step();
      chk("sat_hold", 64'(sc_count), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_step_controller.md
Name: pipeline_step_controller

Overview:
- Sequences the MIPS pipeline by generating the shared `o_enable_pipeline` that feeds the i_enable_pipeline input of every stage top, including execution and memory.
- Accepts debug-host commands over a valid/ready handshake: run continuously, single step, stop, clear.
- When the decode stage flags a HALT instruction, keeps the pipeline enabled long enough to drain the remaining stages, then parks in HALTED.
- Keeps a cycle counter of enabled cycles for the debug unit.

Parameters:
CANT_BITS_ADDR, 11, width of PC / breakpoint address
CANT_BITS_CICLOS, 32, width of enabled-cycle counter
DRAIN_CYCLES, 3, enabled cycles issued after HALT seen in ID (EX, MEM, WB)
CANT_BITS_CMD, 3, command opcode width

Ports:
i_clock  in  1  system clock, all state on rising edge
i_soft_reset  in  1  asynchronous, active-high reset
i_cmd_valid  in  1  command present
i_cmd  in  CANT_BITS_CMD  opcode: 000 NOP, 001 RUN, 010 STEP, 011 STOP, 100 CLEAR, 101 SET_BP, others NOP
i_cmd_data  in  CANT_BITS_ADDR  breakpoint address for SET_BP
o_cmd_ready  out  1  command accepted this cycle when valid&ready
i_halt_detected  in  1  HALT opcode present in ID this cycle
i_pc  in  CANT_BITS_ADDR  PC of instruction in IF
o_enable_pipeline  out  1  pipeline advance enable
o_cycle_count  out  CANT_BITS_CICLOS  number of enabled cycles
o_busy  out  1  state is RUN, STEP or DRAIN
o_halted  out  1  state is HALTED
o_bp_hit  out  1  sticky breakpoint-hit flag
o_led  out  1  copy of o_halted

Behaviour:
- Reset (async, high):
  - state IDLE, drain counter 0, cycle counter 0, breakpoint invalid.
  - All outputs 0 except o_cmd_ready=1.
- Moore FSM. o_enable_pipeline=1 exactly when state ∈ {RUN, STEP, DRAIN}, decoded from the state register (no combinational path from inputs).
- o_cmd_ready=1 in IDLE, RUN, HALTED; 0 in STEP and DRAIN.
  - A command is taken only on valid&ready at a rising edge; it is one-shot.
  - Commands arriving while ready=0 are held by the host and not lost.
- Transitions:
  - IDLE: RUN→RUN; STEP→STEP; CLEAR→IDLE with counter←0 and o_bp_hit←0; STOP/NOP→IDLE.
  - RUN:
    - i_halt_detected → DRAIN, drain counter←DRAIN_CYCLES.
    - Else STOP → IDLE.
    - RUN, STEP and CLEAR are accepted with no effect.
  - STEP: exactly one enabled cycle. Next state is DRAIN if i_halt_detected, else IDLE.
  - DRAIN:
    - Decrement the drain counter each cycle; when it reaches 1 → HALTED, giving exactly DRAIN_CYCLES enabled cycles.
    - If DRAIN_CYCLES=0, RUN/STEP go directly to HALTED on halt with no extra enable.
  - HALTED: only CLEAR acts (→IDLE, counter←0). All other commands are accepted and ignored.
- Simultaneous events:
  - halt and STOP in RUN: halt wins (DRAIN), and STOP is still consumed.
  - halt in any non-enabled state: ignored.
- Cycle counter: +1 on every edge where o_enable_pipeline=1; saturates at all-ones, no wrap.
- Latency: a command accepted at edge N changes the state at edge N, so enable changes in cycle N+1.
- Reset mid-RUN/DRAIN: immediate IDLE, enable drops asynchronously, counters cleared.

Optional Feature:
BREAKPOINT_EN
- Defined:
  - SET_BP loads i_cmd_data into the bp register and sets bp_valid; accepted in IDLE/HALTED, ignored in RUN.
  - In RUN, if bp_valid and i_pc==bp and not i_halt_detected → IDLE next edge, o_bp_hit←1.
  - o_bp_hit clears on an accepted RUN or STEP, or on CLEAR.
  - Halt has priority over the breakpoint.
  - STEP ignores the breakpoint.
- Undefined: SET_BP acts as NOP, o_bp_hit tied 0, no bp registers. The port list is unchanged.

Decomposition:
- Shared package/include: command opcode localparams (CMD_NOP…CMD_SET_BP), state encodings (IDLE, RUN, STEP, DRAIN, HALTED), and the clogb2 function already used across tops.
- One natural sub-module: pipeline_cycle_counter (saturating, enable + sync clear).
- FSM, drain counter and breakpoint logic stay in the top.

Test Plan:
- Reset held 20 ns then released, no commands → enable=0, ready=1, count=0, halted=0.
- RUN accepted, 10 cycles later STOP → enable high for exactly 10 cycles; count=10; state IDLE.
- Three STEP commands back-to-back with valid held → ready drops each STEP cycle; exactly 3 isolated enable pulses; count=3.
- RUN, halt pulsed 1 cycle at cycle 5 → enable stays high 3 more cycles (DRAIN_CYCLES=3); halted=1, led=1, count=8; subsequent RUN ignored; CLEAR → IDLE, count=0.
- In RUN, STOP and halt in the same cycle → DRAIN then HALTED; count includes 3 drain cycles.
- BREAKPOINT_EN: SET_BP 0x014, RUN, i_pc reaches 0x014 at cycle 7 → enable low from the next cycle, bp_hit=1; STEP → bp_hit=0, one pulse. Without macro: same stimulus runs until STOP, bp_hit=0.
